s_iter_div_pe: RTL

S_ITER_DIV_PE -- requirements
Module: s_iter_div_pe

---
 rtl/s_iter_div_pe.sv | 302 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/s_iter_div_pe.sv
// s_iter_div_pe: iterative restoring divider processing element.
// Operands are picked from neighbour results, the own registered result, a constant or a
// neighbour delay output. One quotient bit is produced per advance cycle, followed by a
// two-phase fix-up: sign correction into the working registers, then result registration.
// A delay line forwards a neighbour delay output or this PE's companion result.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   mage_done_i             kernel end: abort to idle, clear result and delay line
//   pea_ready_i             global advance enable; low freezes all state
//   ctrl_pe_i               [2:0] sel_a, [5:3] sel_b, [7:6] op, [8] signed, [11:9] delay_sel
//   reg_const_i             constant operand
//   neigh_pe_op_i/_valid_i  neighbour results and valids (packed, neighbour 0 in LSBs)
//   neigh_delay_op_i/_valid_i neighbour delay outputs and valids
//   ready_o, busy_o         idle / dividing
//   valid_o, pe_res_o       registered result and its valid
//   delay_op_o/_valid_o     last delay-line stage
module s_iter_div_pe #(
   parameter int unsigned N_BITS      = 32,
   parameter int unsigned N_NEIGH     = 4,
   parameter int unsigned DELAY_DEPTH = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      mage_done_i,
   input  logic                      pea_ready_i,
   input  logic [15:0]               ctrl_pe_i,
   input  logic [N_BITS-1:0]         reg_const_i,
   input  logic [N_NEIGH*N_BITS-1:0] neigh_pe_op_i,
   input  logic [N_NEIGH-1:0]        neigh_pe_op_valid_i,
   input  logic [N_NEIGH*N_BITS-1:0] neigh_delay_op_i,
   input  logic [N_NEIGH-1:0]        neigh_delay_op_valid_i,
   output logic                      ready_o,
   output logic                      busy_o,
   output logic                      valid_o,
   output logic [N_BITS-1:0]         pe_res_o,
   output logic [N_BITS-1:0]         delay_op_o,
   output logic                      delay_op_valid_o
);

   localparam int                NNeigh  = int'(N_NEIGH);
   localparam int unsigned       CntW    = $clog2(N_BITS);
   localparam logic [CntW-1:0]   CntLast = CntW'(N_BITS - 1);
   localparam logic [1:0]        OpNop   = 2'b00;
   localparam logic [1:0]        OpRem   = 2'b10;
   localparam logic [1:0]        OpAbs   = 2'b11;

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   // Control decode (bits [15:12] are reserved)
   logic [1:0][2:0] opnd_sel;
   logic [1:0]      op_live;
   logic            sgn_live;
   logic [2:0]      dsel_live;
   logic            unused_ctrl;

   assign opnd_sel    = {ctrl_pe_i[5:3], ctrl_pe_i[2:0]};
   assign op_live     = ctrl_pe_i[7:6];
   assign sgn_live    = ctrl_pe_i[8];
   assign dsel_live   = ctrl_pe_i[11:9];
   assign unused_ctrl = ^ctrl_pe_i[15:12];

   // State
   state_e                            state_q, state_d;
   logic [CntW-1:0]                   cnt_q, cnt_d;
   logic                              fix_ph_q, fix_ph_d;
   logic [N_BITS-1:0]                 quo_q, quo_d;
   logic [N_BITS-1:0]                 rem_q, rem_d;
   logic [N_BITS-1:0]                 mag_b_q, mag_b_d;
   logic                              neg_a_q, neg_a_d;
   logic                              neg_b_q, neg_b_d;
   logic                              dz_q, dz_d;
   logic [1:0]                        op_q, op_d;
   logic [2:0]                        dsel_q, dsel_d;
   logic [N_BITS-1:0]                 pe_res_q, pe_res_d;
   logic                              valid_q, valid_d;
   logic [DELAY_DEPTH-1:0][N_BITS-1:0] dly_q, dly_d;
   logic [DELAY_DEPTH-1:0]            dly_v_q, dly_v_d;

   // Delay selection follows ctrl while idle and the latched copy once a division is running.
   logic [2:0]        dsel_eff;
   logic [N_BITS-1:0] nb_dly;
   logic              nb_dly_v;

   assign dsel_eff = (state_q == StIdle) ? dsel_live : dsel_q;

   always_comb begin
      nb_dly   = '0;
      nb_dly_v = 1'b0;
      for (int i = 0; i < NNeigh; i++) begin
         if (int'(dsel_eff) == i) begin
            nb_dly   = neigh_delay_op_i[i*N_BITS +: N_BITS];
            nb_dly_v = neigh_delay_op_valid_i[i];
         end
      end
   end

   // Operand muxes: index 0 is a (dividend), index 1 is b (divisor)
   logic [1:0][N_BITS-1:0] opnd;
   logic [1:0]             opnd_v;

   always_comb begin
      opnd   = '0;
      opnd_v = '0;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NNeigh; i++) begin
            if (int'(opnd_sel[k]) == i) begin
               opnd[k]   = neigh_pe_op_i[i*N_BITS +: N_BITS];
               opnd_v[k] = neigh_pe_op_valid_i[i];
            end
         end
         if (int'(opnd_sel[k]) == NNeigh) begin
            opnd[k]   = pe_res_q;
            opnd_v[k] = 1'b1;
         end else if (int'(opnd_sel[k]) == NNeigh + 1) begin
            opnd[k]   = reg_const_i;
            opnd_v[k] = 1'b1;
         end else if (int'(opnd_sel[k]) == NNeigh + 2) begin
            opnd[k]   = nb_dly;
            opnd_v[k] = nb_dly_v;
         end
      end
   end

   // Accept and operand conditioning. ABSDIV always treats operands as signed magnitudes.
   logic              accept;
   logic              take_abs;
   logic              neg_a, neg_b;
   logic [N_BITS-1:0] mag_a, mag_b;

   assign accept   = (state_q == StIdle) && (op_live != OpNop) && opnd_v[0] && opnd_v[1] &&
                     pea_ready_i && !mage_done_i;
   assign take_abs = sgn_live || (op_live == OpAbs);
   assign neg_a    = take_abs && opnd[0][N_BITS-1];
   assign neg_b    = take_abs && opnd[1][N_BITS-1];
   assign mag_a    = neg_a ? -opnd[0] : opnd[0];
   assign mag_b    = neg_b ? -opnd[1] : opnd[1];

   // Restoring step: dividend bits are shifted out of quo_q MSB-first while quotient bits
   // enter at the LSB. The extra top bit of trial is the borrow.
   logic [N_BITS:0]   shifted;
   logic [N_BITS+1:0] trial;
   logic              q_bit;

   assign shifted = {rem_q, quo_q[N_BITS-1]};
   assign trial   = {1'b0, shifted} - {2'b00, mag_b_q};
   assign q_bit   = ~trial[N_BITS+1];

   // Sign correction. For b==0 the remainder is restored to the raw dividend by undoing
   // whatever magnitude conversion was applied at accept.
   logic              neg_quo, neg_rem;
   logic [N_BITS-1:0] fix_quo, fix_rem;

   assign neg_quo = !dz_q && (op_q != OpAbs) && (neg_a_q ^ neg_b_q);
   assign neg_rem = neg_a_q && (dz_q || (op_q != OpAbs));
   assign fix_quo = dz_q ? '1 : (neg_quo ? -quo_q : quo_q);
   assign fix_rem = neg_rem ? -rem_q : rem_q;

   // Result selection during the fix-up exit phase
   logic              fix_exit;
   logic [N_BITS-1:0] res_main, res_comp;

   assign fix_exit = (state_q == StFix) && fix_ph_q;
   assign res_main = (op_q == OpRem) ? rem_q : quo_q;
   assign res_comp = (op_q == OpRem) ? quo_q : rem_q;

   // Delay-line input
   logic [N_BITS-1:0] dly_in;
   logic              dly_in_v;

   always_comb begin
      dly_in   = nb_dly;
      dly_in_v = nb_dly_v;
      if (int'(dsel_eff) == NNeigh) begin
         dly_in   = fix_exit ? res_comp : '0;
         dly_in_v = fix_exit;
      end
   end

   // Next state
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      fix_ph_d = fix_ph_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      mag_b_d  = mag_b_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      dz_d     = dz_q;
      op_d     = op_q;
      dsel_d   = dsel_q;
      pe_res_d = pe_res_q;
      valid_d  = valid_q;
      dly_d    = dly_q;
      dly_v_d  = dly_v_q;

      if (mage_done_i) begin
         state_d  = StIdle;
         cnt_d    = '0;
         fix_ph_d = 1'b0;
         pe_res_d = '0;
         valid_d  = 1'b0;
         dly_d    = '0;
         dly_v_d  = '0;
      end else if (pea_ready_i) begin
         // A valid result is consumed by the first advancing cycle after it appears.
         valid_d    = 1'b0;
         dly_d[0]   = dly_in;
         dly_v_d[0] = dly_in_v;
         for (int i = 1; i < int'(DELAY_DEPTH); i++) begin
            dly_d[i]   = dly_q[i-1];
            dly_v_d[i] = dly_v_q[i-1];
         end

         unique case (state_q)
            StIdle: begin
               if (op_live == OpNop) begin
                  pe_res_d = '0;
               end else if (accept) begin
                  quo_d   = mag_a;
                  rem_d   = '0;
                  mag_b_d = mag_b;
                  neg_a_d = neg_a;
                  neg_b_d = neg_b;
                  dz_d    = (opnd[1] == '0);
                  op_d    = op_live;
                  dsel_d  = dsel_live;
                  cnt_d   = '0;
                  state_d = StCalc;
               end
            end
            StCalc: begin
               quo_d = {quo_q[N_BITS-2:0], q_bit};
               rem_d = q_bit ? trial[N_BITS-1:0] : shifted[N_BITS-1:0];
               cnt_d = cnt_q + CntW'(1);
               if (cnt_q == CntLast) begin
                  cnt_d   = '0;
                  state_d = StFix;
               end
            end
            StFix: begin
               if (!fix_ph_q) begin
                  quo_d    = fix_quo;
                  rem_d    = fix_rem;
                  fix_ph_d = 1'b1;
               end else begin
                  pe_res_d = res_main;
                  valid_d  = 1'b1;
                  fix_ph_d = 1'b0;
                  state_d  = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         fix_ph_q <= 1'b0;
         quo_q    <= '0;
         rem_q    <= '0;
         mag_b_q  <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         dz_q     <= 1'b0;
         op_q     <= OpNop;
         dsel_q   <= '0;
         pe_res_q <= '0;
         valid_q  <= 1'b0;
         dly_q    <= '0;
         dly_v_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         fix_ph_q <= fix_ph_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         mag_b_q  <= mag_b_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         dz_q     <= dz_d;
         op_q     <= op_d;
         dsel_q   <= dsel_d;
         pe_res_q <= pe_res_d;
         valid_q  <= valid_d;
         dly_q    <= dly_d;
         dly_v_q  <= dly_v_d;
      end
   end

   assign ready_o          = (state_q == StIdle);
   assign busy_o           = (state_q != StIdle);
   assign valid_o          = valid_q;
   assign pe_res_o         = pe_res_q;
   assign delay_op_o       = dly_q[DELAY_DEPTH-1];
   assign delay_op_valid_o = dly_v_q[DELAY_DEPTH-1];

endmodule
